// File: rtl/hilo_pkg.sv
// hilo_pkg: opcode, FSM state and step-count definitions shared by the HI/LO unit.
// Rev 1.0
`default_nettype none

package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int STEPS = 32;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/div_iter_step.sv
// div_iter_step: one combinational restoring-division step on unsigned magnitudes.
// Rev 1.0
`default_nettype none

module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem < divisor holds between steps, so XLEN+1 bits carry the trial-subtract sign.
  assign shifted  = {rem, quo[XLEN-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign rem_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], ~diff[XLEN]};

endmodule

`default_nettype wire

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative multiply/divide unit owning the HI/LO registers.
// Rev 1.0 -- define HILO_FAST_MULT_EN for single-cycle multiply.
`default_nettype none

module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs_i,
  input  logic [XLEN-1:0] rt_i,
  input  logic            flush_i,
  input  logic            mf_req_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  acc_hi;
  logic [XLEN-1:0]  acc_lo;
  logic [XLEN-1:0]  divisor;
  logic             neg_res;
  logic             neg_rem;
  logic             is_div;
  logic             div_zero;

  logic            op_signed;
  logic [XLEN-1:0] rs_mag;
  logic [XLEN-1:0] rt_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Datapath works on magnitudes; signs are re-applied at write-back.
  assign op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign rs_mag    = neg_if(rs_i, op_signed & rs_i[XLEN-1]);
  assign rt_mag    = neg_if(rt_i, op_signed & rt_i[XLEN-1]);

  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, divisor} : '0);

  div_iter_step #(.XLEN(XLEN)) u_div_step (
    .rem      (acc_hi),
    .quo      (acc_lo),
    .divisor  (divisor),
    .rem_next (div_rem),
    .quo_next (div_quo)
  );

  assign step_hi = (state == S_DIV) ? div_rem : mul_sum[XLEN:1];
  assign step_lo = (state == S_DIV) ? div_quo : {mul_sum[0], acc_lo[XLEN-1:1]};

`ifdef HILO_FAST_MULT_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, rs_mag} * {{XLEN{1'b0}}, rt_mag};
`endif

  assign busy_o  = (state != S_IDLE);
  assign stall_o = busy_o & (mf_req_i | op_valid_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      divisor  <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      hi_o     <= '0;
      lo_o     <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid_i && !flush_i) begin
            case (op_i)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                acc_hi   <= '0;
                acc_lo   <= rs_mag;
                divisor  <= rt_mag;
                count    <= '0;
                neg_res  <= op_signed & (rs_i[XLEN-1] ^ rt_i[XLEN-1]);
                neg_rem  <= op_signed & rs_i[XLEN-1];
                is_div   <= op_i[1];
                div_zero <= (rt_i == '0);
                state    <= op_i[1] ? S_DIV : S_MUL;
`ifdef HILO_FAST_MULT_EN
                if (!op_i[1]) begin
                  {acc_hi, acc_lo} <= fast_prod;
                  state            <= S_FIN;
                end
`endif
              end
              OP_MTHI: hi_o <= rs_i;
              OP_MTLO: lo_o <= rs_i;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (flush_i) begin
            state <= S_IDLE;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            count  <= count + 1'b1;
            if (count == LAST_STEP) state <= S_FIN;
          end
        end
        S_FIN: begin
          // Write-back is committed once FIN is reached; flush no longer applies.
          if (is_div) begin
            lo_o <= div_zero ? '1 : neg_if(acc_lo, neg_res);
            hi_o <= neg_if(acc_hi, neg_rem);
          end else begin
            {hi_o, lo_o} <= neg_res ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
          end
          done_o <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: scoreboard-based self-checking bench for hilo_muldiv.
// Rev 1.0
`default_nettype none

module tb_hilo_muldiv;
  import hilo_pkg::*;

`ifdef HILO_FAST_MULT_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_sel = 3'd0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        flush = 1'b0;
  logic        mf_req = 1'b0;
  logic        busy_o, stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  hilo_muldiv #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid_i (op_valid),
    .op_i       (op_sel),
    .rs_i       (rs),
    .rt_i       (rt),
    .flush_i    (flush),
    .mf_req_i   (mf_req),
    .busy_o     (busy_o),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    longint sa, sbv;
    int ia, ib;
    logic [63:0] p;
    r.hi = '0;
    r.lo = '0;
    case (op)
      OP_MULT: begin
        sa = $signed(a); sbv = $signed(b); p = sa * sbv;
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      OP_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      OP_DIV: begin
        if (b == 0) begin r.lo = 32'hFFFF_FFFF; r.hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r.lo = a; r.hi = 0; end
        else begin ia = $signed(a); ib = $signed(b); r.lo = ia / ib; r.hi = ia % ib; end
      end
      OP_DIVU: begin
        if (b == 0) begin r.lo = 32'hFFFF_FFFF; r.hi = a; end
        else begin r.lo = a / b; r.hi = a % b; end
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    @(negedge clk);
    op_valid = 1'b1; op_sel = op; rs = a; rt = b;
    if (push) sb.push_back(model(op, a, b));
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, output int edges, output bit got);
    edges = start;
    got = 1'b0;
    while (edges < 80) begin
      @(posedge clk);
      edges++;
      #1;
      if (done_o) begin got = 1'b1; break; end
    end
  endtask

  task automatic count_dones(input int n, output int dones);
    dones = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (done_o) dones++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; op_valid = 1'b1; mf_req = 1'b1; op_sel = OP_MULT;
    #12;
    total++;
    if ({busy_o, stall_o, done_o} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl: got busy/stall/done=%b want 000", {busy_o, stall_o, done_o});
    end
    total++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
      bad++; $display("FAIL reset_hilo: got hi=%h lo=%h want 0/0", hi_o, lo_o);
    end
    @(negedge clk);
    op_valid = 1'b0; mf_req = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_mult;
    logic [2:0]  ops [8] = '{OP_MULT, OP_MULTU, OP_MULT, OP_MULT, OP_MULTU, OP_MULT, OP_MULTU, OP_MULT};
    logic [31:0] as  [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h8000_0000, 32'd7, 32'd0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h7FFF_FFFF};
    logic [31:0] bs  [8] = '{32'd3, 32'd3, 32'h8000_0000, 32'hFFFF_FFF9, 32'd12345, 32'hF00D_CAFE, 32'hFFFF_FFFF, 32'h8000_0001};
    int e;
    bit got;
    exp_t x;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i], 1'b1);
      wait_done(1, e, got);
      total++;
      if (!got || e != MUL_LAT) begin
        bad++; $display("FAIL mul_latency[%0d]: got done=%0b edges=%0d want 1/%0d", i, got, e, MUL_LAT);
      end
      x = sb.pop_front();
      total++;
      if (hi_o !== x.hi || lo_o !== x.lo) begin
        bad++; $display("FAIL mul_result[%0d]: got hi=%h lo=%h want hi=%h lo=%h", i, hi_o, lo_o, x.hi, x.lo);
      end
      @(posedge clk); #1;
      total++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++; $display("FAIL mul_pulse[%0d]: got done=%b busy=%b want 0/0", i, done_o, busy_o);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [9] = '{OP_DIVU, OP_DIV, OP_DIV, OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] as  [9] = '{32'd100, 32'hFFFF_FFF9, 32'h0000_1234, 32'h8000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FF00, 32'd7, 32'h8000_0000, 32'h8765_4321};
    logic [31:0] bs  [9] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1000};
    int e;
    bit got;
    exp_t x;
    for (int i = 0; i < 9; i++) begin
      issue(ops[i], as[i], bs[i], 1'b1);
      wait_done(1, e, got);
      total++;
      if (!got || e != DIV_LAT) begin
        bad++; $display("FAIL div_latency[%0d]: got done=%0b edges=%0d want 1/%0d", i, got, e, DIV_LAT);
      end
      x = sb.pop_front();
      total++;
      if (hi_o !== x.hi || lo_o !== x.lo) begin
        bad++; $display("FAIL div_result[%0d]: got hi=%h lo=%h want hi=%h lo=%h", i, hi_o, lo_o, x.hi, x.lo);
      end
    end
  endtask

  task automatic test_mt;
    @(negedge clk);
    op_valid = 1'b1; op_sel = OP_MTLO; rs = 32'hCAFE_BABE;
    #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL mtlo_stall: got %b want 0", stall_o); end
    @(posedge clk); #1 op_valid = 1'b0;
    @(negedge clk);
    mf_req = 1'b1;
    #1;
    total++;
    if (lo_o !== 32'hCAFE_BABE || stall_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL mflo: got lo=%h stall=%b busy=%b want cafebabe/0/0", lo_o, stall_o, busy_o);
    end
    @(negedge clk);
    mf_req = 1'b0;
  endtask

  task automatic test_stall;
    int e;
    bit exp_stall;
    exp_t x;
    issue(OP_MULT, 32'h0001_0003, 32'hFFFF_0005, 1'b1);
    e = 1;
    while (e <= MUL_LAT) begin
      @(negedge clk);
      if (e >= 5) mf_req = 1'b1;
      #1;
      exp_stall = (e >= 5) && (e < MUL_LAT);
      total++;
      if (stall_o !== exp_stall) begin
        bad++; $display("FAIL mf_stall[e=%0d]: got %b want %b", e, stall_o, exp_stall);
      end
      if (e == MUL_LAT) break;
      @(posedge clk);
      e++;
    end
    x = sb.pop_front();
    total++;
    if (hi_o !== x.hi || lo_o !== x.lo || done_o !== 1'b1) begin
      bad++; $display("FAIL mf_result: got hi=%h lo=%h done=%b want hi=%h lo=%h done=1", hi_o, lo_o, done_o, x.hi, x.lo);
    end
    @(negedge clk);
    mf_req = 1'b0;
  endtask

  task automatic test_flush;
    int e;
    int dones;
    issue(OP_MTHI, 32'h1111_1111, 32'd0, 1'b0);
    issue(OP_MTLO, 32'h2222_2222, 32'd0, 1'b0);
    issue(OP_DIVU, 32'd1000, 32'd3, 1'b0);
    e = 1;
    while (e < 10) begin @(posedge clk); e++; end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("FAIL flush_idle: got busy=%b done=%b want 0/0", busy_o, done_o);
    end
    count_dones(40, dones);
    total++;
    if (dones != 0 || hi_o !== 32'h1111_1111 || lo_o !== 32'h2222_2222) begin
      bad++; $display("FAIL flush_hilo: got dones=%0d hi=%h lo=%h want 0/11111111/22222222", dones, hi_o, lo_o);
    end
  endtask

  task automatic test_back_to_back;
    int e;
    int e2;
    int dones;
    bit got;
    exp_t x;
    // op issued while busy must be ignored
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
    e = 1;
    repeat (4) begin @(posedge clk); e++; end
    @(negedge clk);
    op_valid = 1'b1; op_sel = OP_MULT; rs = 32'd5; rt = 32'd6;
    #1;
    total++;
    if (stall_o !== 1'b1) begin bad++; $display("FAIL busy_op_stall: got %b want 1", stall_o); end
    @(posedge clk); e++;
    #1 op_valid = 1'b0;
    wait_done(e, e2, got);
    x = sb.pop_front();
    total++;
    if (!got || e2 != DIV_LAT || hi_o !== x.hi || lo_o !== x.lo) begin
      bad++; $display("FAIL busy_ignore: got done=%0b edges=%0d hi=%h lo=%h want 1/%0d hi=%h lo=%h",
                      got, e2, hi_o, lo_o, DIV_LAT, x.hi, x.lo);
    end
    // immediate follow-on op
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(1, e, got);
    x = sb.pop_front();
    total++;
    if (!got || e != MUL_LAT || hi_o !== x.hi || lo_o !== x.lo) begin
      bad++; $display("FAIL b2b_mul: got done=%0b edges=%0d hi=%h lo=%h want 1/%0d hi=%h lo=%h",
                      got, e, hi_o, lo_o, MUL_LAT, x.hi, x.lo);
    end
    count_dones(40, dones);
    total++;
    if (dones != 0) begin bad++; $display("FAIL stray_done: got %0d pulses want 0", dones); end
    // reserved opcodes
    issue(3'd6, 32'h5555_5555, 32'd1, 1'b0);
    issue(3'd7, 32'h6666_6666, 32'd1, 1'b0);
    total++;
    if (busy_o !== 1'b0 || hi_o !== x.hi || lo_o !== x.lo) begin
      bad++; $display("FAIL reserved_op: got busy=%b hi=%h lo=%h want 0 hi=%h lo=%h", busy_o, hi_o, lo_o, x.hi, x.lo);
    end
    // flush beats op in IDLE
    @(negedge clk);
    op_valid = 1'b1; flush = 1'b1; op_sel = OP_MULT; rs = 32'd9; rt = 32'd9;
    @(posedge clk);
    #1;
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL flush_op_mul: got busy=%b want 0", busy_o); end
    @(negedge clk);
    op_sel = OP_MTLO; rs = 32'hBAD0_BAD0;
    @(posedge clk);
    #1 op_valid = 1'b0; flush = 1'b0;
    total++;
    if (lo_o !== x.lo) begin bad++; $display("FAIL flush_op_mtlo: got lo=%h want %h", lo_o, x.lo); end
    // flush during FIN keeps the write-back
    issue(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    e = 1;
    while (e < MUL_LAT - 1) begin @(posedge clk); e++; end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); e++;
    #1 flush = 1'b0;
    x = sb.pop_front();
    total++;
    if (done_o !== 1'b1 || hi_o !== x.hi || lo_o !== x.lo) begin
      bad++; $display("FAIL fin_flush: got done=%b hi=%h lo=%h want 1 hi=%h lo=%h", done_o, hi_o, lo_o, x.hi, x.lo);
    end
  endtask

  task automatic test_reset_mid;
    int e;
    int dones;
    issue(OP_MULT, 32'h0BAD_F00D, 32'h1234_5678, 1'b0);
    e = 1;
    while (e < 10) begin @(posedge clk); e++; end
    @(negedge clk);
    rst_n = 1'b0; mf_req = 1'b1; op_valid = 1'b1;
    #1;
    total++;
    if ({busy_o, stall_o, done_o} !== 3'b000 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      bad++; $display("FAIL reset_mid: got busy/stall/done=%b hi=%h lo=%h want 000/0/0",
                      {busy_o, stall_o, done_o}, hi_o, lo_o);
    end
    @(negedge clk);
    rst_n = 1'b1; mf_req = 1'b0; op_valid = 1'b0;
    count_dones(40, dones);
    total++;
    if (dones != 0 || busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      bad++; $display("FAIL reset_abort: got dones=%0d busy=%b hi=%h lo=%h want 0/0/0/0", dones, busy_o, hi_o, lo_o);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
